// File: rtl/grf_wport_arb.sv
// grf_wport_arb: shares the single GRF write port between the WB stage and
// the multiply/divide unit. WB always wins. MDU results queue in a small
// FIFO and drain into idle write slots. A starvation counter raises
// stall_req when a queued result has been blocked for too long.
module grf_wport_arb #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic [31:0] wb_pc,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_addr,
  input  logic [31:0] md_data,
  input  logic [31:0] md_pc,
  output logic        grf_we,
  output logic [4:0]  grf_a3,
  output logic [31:0] grf_wd,
  output logic [31:0] grf_pc,
  output logic [31:0] busy_mask,
  output logic        stall_req
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [3:0]  LIMIT    = 4'(STARVE_LIMIT);

  logic [DEPTH-1:0] vld;
  logic [4:0]       addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      pc_q   [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [3:0]       starve_cnt;

  logic wb_live;
  logic head_present;
  logic head_vld;
  logic pop;
  logic push;
  logic push_store;
  logic blocked;

  assign wb_live      = wb_we && (wb_addr != 5'd0);
  assign head_present = (count != '0);
  assign head_vld     = head_present && vld[rd_ptr];
  // A squashed head is dropped even while WB owns the port; a valid head
  // only leaves when it is actually granted.
  assign pop          = head_present && (!vld[rd_ptr] || !wb_live);
  assign md_ready     = (count != FULL_CNT);
  assign push         = md_valid && md_ready;
  assign push_store   = push && (md_addr != 5'd0);
  // A head about to be squashed by this WB write is not counted as starving.
  assign blocked      = head_vld && wb_live && (addr_q[rd_ptr] != wb_addr);
  assign stall_req    = (starve_cnt == LIMIT);

  // Write-port grant: WB first, then a valid FIFO head, otherwise idle.
  always_comb begin
    grf_we = 1'b0;
    grf_a3 = 5'd0;
    grf_wd = 32'd0;
    grf_pc = 32'd0;
    if (reset) begin
      if (wb_live) begin
        grf_we = 1'b1;
        grf_a3 = wb_addr;
        grf_wd = wb_data;
        grf_pc = wb_pc;
      end else if (head_vld) begin
        grf_we = 1'b1;
        grf_a3 = addr_q[rd_ptr];
        grf_wd = data_q[rd_ptr];
        grf_pc = pc_q[rd_ptr];
      end
    end
  end

  // Pending-write mask from the stored valid entries only.
  always_comb begin
    busy_mask = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i]) busy_mask[addr_q[i]] = 1'b1;
    end
  end

  // FIFO control: valid bits, pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Squash first so an entry enqueued this edge with the same address
      // survives.
      for (int i = 0; i < DEPTH; i++) begin
        if (wb_live && (addr_q[i] == wb_addr)) vld[i] <= 1'b0;
      end
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + 1'b1;
      end
      if (push_store) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      case ({push_store, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO payload storage; contents are qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (push_store) begin
      addr_q[wr_ptr] <= md_addr;
      data_q[wr_ptr] <= md_data;
      pc_q[wr_ptr]   <= md_pc;
    end
  end

  // Starvation counter: saturating count of cycles the valid head is blocked.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= 4'd0;
    end else if (blocked) begin
      if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
    end else begin
      starve_cnt <= 4'd0;
    end
  end

endmodule

// File: doc/grf_wport_arb.md
# grf_wport_arb

Write-port arbiter and scheduler for the 32×32 general register file in the pipelined MIPS core. It shares the file's single write port between the WB stage and the multi-cycle multiply/divide unit (MDU). WB always has priority. MDU results wait in a small FIFO and drain into idle write slots. The block exports a pending-write mask for the hazard unit and a starvation stall request for the pipeline controller.

## Interface
Parameters:
- DEPTH, 2, MDU result FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 4, consecutive blocked cycles before stall_req (1..15)

Ports:
- clk  in  1  single clock. One clock `clk`; reset `reset` is asynchronous and active-low.
- reset  in  1  asynchronous, active-low
- wb_we  in  1  WB stage write request, never back-pressured
- wb_addr  in  5  WB destination register
- wb_data  in  32  WB write data
- wb_pc  in  32  WB instruction PC
- md_valid  in  1  MDU result valid
- md_ready  out  1  FIFO can accept; equals !full
- md_addr  in  5  MDU destination register
- md_data  in  32  MDU result
- md_pc  in  32  MDU instruction PC
- grf_we  out  1  register-file write enable
- grf_a3  out  5  register-file write address
- grf_wd  out  32  register-file write data
- grf_pc  out  32  PC forwarded to the register-file write trace
- busy_mask  out  32  bit r=1 while a valid FIFO entry targets register r
- stall_req  out  1  pipeline must insert WB bubbles

## Operation
- WB request is live when wb_we=1 and wb_addr≠0. A WB request with wb_addr=0 is ignored entirely.
- Grant, combinational:
  - If the WB request is live, drive grf_* from wb_* with grf_we=1.
  - Otherwise, if the FIFO head is valid, drive grf_* from the head with grf_we=1 and pop the head.
  - Otherwise grf_we=0 and grf_a3/grf_wd/grf_pc=0.
- Enqueue at clk edge when md_valid && md_ready.
  - md_addr=0 completes the handshake but stores nothing.
  - Otherwise the entry is stored with a valid bit.
- Squash: a live WB request clears the valid bit of every FIFO entry whose addr equals wb_addr, at that edge. A newer WB result supersedes queued MDU results.
- Invalid (squashed) head: popped at the next edge regardless of WB activity. It never drives grf_we.
- busy_mask: OR of one-hot(addr) over valid entries, from registered state only.
- Starvation counter, 4-bit:
  - Increments, saturating at STARVE_LIMIT, each cycle a valid head exists and WB holds the port.
  - Clears when the head is granted or no valid head exists.
- stall_req = (counter == STARVE_LIMIT), decoded from the register.

## Timing
- Reset (asynchronous, while reset=0):
  - FIFO is emptied, all valid bits 0, pointers 0, counter 0.
  - busy_mask=0, stall_req=0, md_ready=1.
  - grf_we forced to 0.
- Latency: an MDU result accepted at edge t can write at the earliest in cycle t+1. There is no bypass from md_* to grf_*.
- md_ready depends only on registered occupancy. It stays 0 when full, even if a pop occurs the same cycle.
- Simultaneous enqueue and pop while not full: both occur, occupancy unchanged.
- Simultaneous enqueue and squash with the same address:
  - Squash applies only to entries already stored.
  - The incoming entry stays valid.
- Pointers wrap modulo DEPTH. Occupancy uses a log2(DEPTH)+1-bit count.
- stall_req:
  - Rises in the cycle after the counter reaches the limit, i.e. after STARVE_LIMIT blocked cycles.
  - Falls in the cycle after the head is granted or squashed.
- The pipeline deasserts wb_we while stall_req=1. If wb_we is still asserted, WB still wins and no data is lost.
- Reset asserted mid-operation discards all queued results. The MDU re-issues them.

## Test plan
- Reset: hold reset=0 with md_valid=1 and wb_we=1 -> grf_we=0, md_ready=1, busy_mask=0, stall_req=0. After release, FIFO is empty.
- MDU alone: cycle 0 md_valid=1, md_addr=5, md_data=0x00001234, WB idle -> busy_mask=0x20. Cycle 1: grf_we=1, grf_a3=5, grf_wd=0x1234, grf_pc=md_pc. Cycle 2: busy_mask=0.
- Priority/starvation (STARVE_LIMIT=4):
  - Stimulus: queue $9, then WB writes $3 every cycle.
  - Response: grf_a3=3 on each of those cycles; stall_req=1 from the 5th blocked cycle.
  - Stimulus: drop wb_we.
  - Response: $9 is written that cycle; stall_req=0 the following cycle.
- Full (DEPTH=2):
  - Stimulus: WB busy; enqueue $1 and $2.
  - Response: md_ready=0 and a third md_valid holds.
  - Stimulus: WB idle.
  - Response: $1, then $2 drain in order; md_ready=1 after the first pop.
- Squash:
  - Stimulus: FIFO holds $7=0xAAAA; WB writes $7=0xBBBB.
  - Response: busy_mask[7]=0 next cycle; no later grf_we with a3=7 and data 0xAAAA; the slot is freed within one cycle.
- Zero register: WB wb_addr=0 and MDU md_addr=0 -> no grf_we, no FIFO occupancy, md handshake completes. A queued entry drains in the same cycle as the ignored WB request.
